// File: rtl/sirv_shadow_reg_vec_pkg.sv
// Shared sirv peripheral definitions for the shadowed register vector.
// Write-operation encodings applied by each byte lane to the shadow value.
package sirv_shadow_reg_vec_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_SET    = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_TOGGLE = 2'd3
    } wop_e;

    localparam int unsigned LANE_BITS = 8;

endpackage

// File: rtl/sirv_shadow_reg_vec_lane.sv
// One byte lane of shadow next-value logic: applies the write operation
// when the lane strobe is set, otherwise passes the old shadow byte through.
module sirv_shadow_reg_lane
    import sirv_shadow_reg_vec_pkg::*;
(
    input  logic [1:0] op,
    input  logic       strb,
    input  logic [7:0] d,
    input  logic [7:0] shadow,
    output logic [7:0] shadow_nxt
);

    // Lane next-value selection
    always_comb begin
        shadow_nxt = shadow;
        if (strb) begin
            case (wop_e'(op))
                OP_WRITE:  shadow_nxt = d;
                OP_SET:    shadow_nxt = shadow | d;
                OP_CLEAR:  shadow_nxt = shadow & ~d;
                OP_TOGGLE: shadow_nxt = shadow ^ d;
                default:   shadow_nxt = shadow;
            endcase
        end else begin
            shadow_nxt = shadow;
        end
    end

endmodule

// File: rtl/sirv_shadow_reg_vec.sv
// Shadowed control register: byte-lane writes land in a shadow copy and are
// applied to the active value on commit; a sticky lock blocks further writes.
module sirv_shadow_reg_vec
    import sirv_shadow_reg_vec_pkg::*;
#(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_wen,
    input  logic [1:0]           io_wop,
    input  logic [WIDTH/8-1:0]   io_wstrb,
    input  logic [WIDTH-1:0]     io_d,
    input  logic                 io_commit,
    input  logic                 io_lock,
    output logic [WIDTH-1:0]     io_q,
    output logic [WIDTH-1:0]     io_shadow,
    output logic                 io_pending,
    output logic                 io_locked,
    output logic                 io_changed,
    output logic                 io_werr
);

    localparam int unsigned LANES = WIDTH / LANE_BITS;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] shadow_r;
    logic             pending_r;
    logic             locked_r;
    logic             changed_r;
    logic             werr_r;

    logic [WIDTH-1:0] lane_out_s;
    logic [WIDTH-1:0] shadow_post_s;
    logic             write_ok_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sirv_shadow_reg_lane u_lane (
            .op         (io_wop),
            .strb       (io_wstrb[g]),
            .d          (io_d[g*LANE_BITS +: LANE_BITS]),
            .shadow     (shadow_r[g*LANE_BITS +: LANE_BITS]),
            .shadow_nxt (lane_out_s[g*LANE_BITS +: LANE_BITS])
        );
    end

    // A lock request in the same cycle already blocks the write
    always_comb begin
        write_ok_s    = io_wen & ~locked_r & ~io_lock;
        shadow_post_s = shadow_r;
        if (write_ok_s) begin
            shadow_post_s = lane_out_s;
        end else begin
            shadow_post_s = shadow_r;
        end
    end

    // State registers; commit sees the post-write shadow (write-through)
    always_ff @(posedge clock) begin
        if (!reset) begin
            q_r       <= RESET_VAL;
            shadow_r  <= RESET_VAL;
            pending_r <= 1'b0;
            locked_r  <= 1'b0;
            changed_r <= 1'b0;
            werr_r    <= 1'b0;
        end else begin
            shadow_r  <= shadow_post_s;
            locked_r  <= locked_r | io_lock;
            werr_r    <= io_wen & ~write_ok_s;
            changed_r <= io_commit & (shadow_post_s != q_r);
            if (io_commit) begin
                q_r       <= shadow_post_s;
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r | write_ok_s;
            end
        end
    end

    assign io_q       = q_r;
    assign io_shadow  = shadow_r;
    assign io_pending = pending_r;
    assign io_locked  = locked_r;
    assign io_changed = changed_r;
    assign io_werr    = werr_r;

endmodule

// File: tb/tb_sirv_shadow_reg_vec.sv
// Self-checking bench for sirv_shadow_reg_vec (WIDTH=32, RESET_VAL=0):
// a reference model pushes expected outputs per cycle, scenario tasks pop and compare.
module tb_sirv_shadow_reg_vec;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_wen;
    logic [1:0]  io_wop;
    logic [3:0]  io_wstrb;
    logic [31:0] io_d;
    logic        io_commit;
    logic        io_lock;
    logic [31:0] io_q;
    logic [31:0] io_shadow;
    logic        io_pending;
    logic        io_locked;
    logic        io_changed;
    logic        io_werr;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] shadow;
        logic        pending;
        logic        locked;
        logic        changed;
        logic        werr;
    } obs_t;

    obs_t exp_q[$];
    obs_t m;
    int   total = 0;
    int   fails = 0;

    sirv_shadow_reg_vec #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_wen     (io_wen),
        .io_wop     (io_wop),
        .io_wstrb   (io_wstrb),
        .io_d       (io_d),
        .io_commit  (io_commit),
        .io_lock    (io_lock),
        .io_q       (io_q),
        .io_shadow  (io_shadow),
        .io_pending (io_pending),
        .io_locked  (io_locked),
        .io_changed (io_changed),
        .io_werr    (io_werr)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic obs_t get_obs();
        obs_t o;
        o.q       = io_q;
        o.shadow  = io_shadow;
        o.pending = io_pending;
        o.locked  = io_locked;
        o.changed = io_changed;
        o.werr    = io_werr;
        return o;
    endfunction

    // Drive one cycle of stimulus, advance the model, queue the expected result.
    task automatic step(input logic rst, input logic wen, input logic [1:0] op,
                        input logic [3:0] strb, input logic [31:0] d,
                        input logic commit, input logic lock);
        logic [31:0] mask;
        logic [31:0] dm;
        logic [31:0] nsh;
        logic        acc;
        reset = rst; io_wen = wen; io_wop = op; io_wstrb = strb;
        io_d = d; io_commit = commit; io_lock = lock;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        dm = d & mask;
        if (!rst) begin
            m = '0;
        end else begin
            acc = wen && !m.locked && !lock;
            nsh = m.shadow;
            if (acc) begin
                if (op == 2'd0)      nsh = (m.shadow & ~mask) | dm;
                else if (op == 2'd1) nsh = m.shadow | dm;
                else if (op == 2'd2) nsh = m.shadow & ~dm;
                else                 nsh = m.shadow ^ dm;
            end
            m.werr    = wen && !acc;
            m.changed = commit && (nsh != m.q);
            if (commit) m.q = nsh;
            m.pending = commit ? 1'b0 : (m.pending || acc);
            m.locked  = m.locked || lock;
            m.shadow  = nsh;
        end
        exp_q.push_back(m);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        obs_t o, e;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 2'd0, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1);
            o = get_obs(); e = exp_q.pop_front(); total++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset[%0d] got=%h want=%h", i, o, e);
            end
        end
        total++;
        if (io_q !== 32'h0 || io_shadow !== 32'h0 || io_locked !== 1'b0) begin
            fails++;
            $display("FAIL reset_const got q=%h sh=%h lk=%b want 0/0/0", io_q, io_shadow, io_locked);
        end
    endtask

    task automatic test_write_commit();
        obs_t o, e;
        step(1'b1, 1'b1, 2'd0, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_shadow !== 32'h1234_5678 || io_pending !== 1'b1 || io_q !== 32'h0) begin
            fails++;
            $display("FAIL write got=%h want=%h", o, e);
        end
        step(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_q !== 32'h1234_5678 || io_changed !== 1'b1 || io_pending !== 1'b0) begin
            fails++;
            $display("FAIL commit got=%h want=%h", o, e);
        end
        idle();
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_changed !== 1'b0) begin
            fails++;
            $display("FAIL changed_pulse got=%h want=%h", o, e);
        end
    endtask

    task automatic test_ops();
        obs_t        o, e;
        logic [1:0]  ops  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [3:0]  strbs[4] = '{4'hF, 4'h2, 4'h1, 4'h8};
        logic [31:0] ds   [4] = '{32'h0000_00FF, 32'h0000_FF00, 32'h0000_000F, 32'hFFFF_FFFF};
        logic [31:0] want [4] = '{32'h0000_00FF, 32'h0000_FFFF, 32'h0000_FFF0, 32'hFF00_FFF0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, ops[i], strbs[i], ds[i], 1'b0, 1'b0);
            o = get_obs(); e = exp_q.pop_front(); total++;
            if (o !== e || io_shadow !== want[i]) begin
                fails++;
                $display("FAIL op[%0d] got=%h want=%h shadow_want=%h", i, o, e, want[i]);
            end
        end
    endtask

    task automatic test_write_through();
        obs_t o, e;
        step(1'b1, 1'b1, 2'd0, 4'hF, 32'hA5A5_A5A5, 1'b1, 1'b0);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_q !== 32'hA5A5_A5A5 || io_pending !== 1'b0 || io_changed !== 1'b1) begin
            fails++;
            $display("FAIL write_through got=%h want=%h", o, e);
        end
    endtask

    task automatic test_no_change_commit();
        obs_t o, e;
        step(1'b1, 1'b1, 2'd0, 4'hF, 32'h0000_0005, 1'b1, 1'b0);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e) begin
            fails++;
            $display("FAIL set_five got=%h want=%h", o, e);
        end
        step(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_changed !== 1'b0 || io_q !== 32'h5) begin
            fails++;
            $display("FAIL no_change got=%h want=%h", o, e);
        end
    endtask

    task automatic test_wstrb_zero();
        obs_t o, e;
        step(1'b1, 1'b1, 2'd0, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_pending !== 1'b1 || io_shadow !== 32'h5) begin
            fails++;
            $display("FAIL wstrb_zero got=%h want=%h", o, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                 4'($urandom_range(15, 0)), 32'($urandom()), 1'($urandom_range(1, 0)), 1'b0);
            o = get_obs(); e = exp_q.pop_front(); total++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_lock();
        obs_t o, e;
        step(1'b1, 1'b1, 2'd0, 4'hF, 32'h1, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        step(1'b1, 1'b1, 2'd0, 4'hF, 32'h3, 1'b0, 1'b1);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_werr !== 1'b1 || io_shadow !== 32'h1 || io_locked !== 1'b1) begin
            fails++;
            $display("FAIL lock_same_cycle got=%h want=%h", o, e);
        end
        step(1'b1, 1'b1, 2'd0, 4'hF, 32'h2, 1'b0, 1'b0);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_werr !== 1'b1 || io_shadow !== 32'h1) begin
            fails++;
            $display("FAIL locked_write got=%h want=%h", o, e);
        end
        step(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_q !== 32'h1 || io_werr !== 1'b0 || io_locked !== 1'b1) begin
            fails++;
            $display("FAIL locked_commit got=%h want=%h", o, e);
        end
    endtask

    task automatic test_reset_override();
        obs_t o, e;
        step(1'b0, 1'b1, 2'd0, 4'hF, 32'h0000_DEAD, 1'b1, 1'b1);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_shadow !== 32'h0 || io_q !== 32'h0 || io_pending !== 1'b0 || io_locked !== 1'b0) begin
            fails++;
            $display("FAIL reset_override got=%h want=%h", o, e);
        end
        step(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        o = get_obs(); e = exp_q.pop_front(); total++;
        if (o !== e || io_q !== 32'h0 || io_changed !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_commit got=%h want=%h", o, e);
        end
    endtask

    initial begin
        reset = 1'b0; io_wen = 1'b0; io_wop = 2'd0; io_wstrb = 4'h0;
        io_d = 32'h0; io_commit = 1'b0; io_lock = 1'b0;
        m = '0;
        @(negedge clock);
        test_reset();
        test_write_commit();
        test_ops();
        test_write_through();
        test_no_change_commit();
        test_wstrb_zero();
        test_back_to_back();
        test_lock();
        test_reset_override();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/sirv_shadow_reg_vec.md
SIRV_SHADOW_REG_VEC -- requirements
Module: sirv_shadow_reg_vec

Interface
REQ-001 SHALL have parameter WIDTH, default 32: register width in bits; multiple of 8, range 8..64.
REQ-002 SHALL have parameter RESET_VAL, default 0: WIDTH-bit value loaded into the active and shadow registers on reset.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset; a low level sampled at a clock edge resets the block.
REQ-005 SHALL have port io_wen, input, 1: write request to the shadow register.
REQ-006 SHALL have port io_wop, input, 2: write operation; 0=WRITE, 1=SET, 2=CLEAR, 3=TOGGLE.
REQ-007 SHALL have port io_wstrb, input, WIDTH/8: byte-lane enables for the write.
REQ-008 SHALL have port io_d, input, WIDTH: write data, or the bit mask for SET/CLEAR/TOGGLE.
REQ-009 SHALL have port io_commit, input, 1: transfer the shadow register to the active register.
REQ-010 SHALL have port io_lock, input, 1: sticky write lock request.
REQ-011 SHALL have port io_q, output, WIDTH: active register value.
REQ-012 SHALL have port io_shadow, output, WIDTH: shadow register value.
REQ-013 SHALL have port io_pending, output, 1: the shadow holds an accepted write that has not yet been committed.
REQ-014 SHALL have port io_locked, output, 1: lock flag.
REQ-015 SHALL have port io_changed, output, 1: one-cycle pulse when a commit alters io_q.
REQ-016 SHALL have port io_werr, output, 1: one-cycle pulse when a write is rejected because of lock.

Function
REQ-017 Per enabled byte lane, the new shadow value SHALL be: WRITE = d; SET = shadow|d; CLEAR = shadow&~d; TOGGLE = shadow^d. Disabled lanes keep the old shadow bits.
REQ-018 An accepted write SHALL update io_shadow at the next edge (1-cycle latency) and set io_pending.
REQ-019 A write with io_wstrb = 0 SHALL be accepted: io_pending is set, but the shadow value does not change.
REQ-020 On io_commit, io_q SHALL take the post-write shadow value at the next edge; a write in the same cycle is included (write-through).
REQ-021 On io_commit, io_pending SHALL clear at the next edge, including when a write is accepted in the same cycle.
REQ-022 io_changed SHALL be high for exactly the one cycle after a commit edge, and only if the new io_q differs from the old io_q.
REQ-023 io_changed SHALL NOT be asserted by a commit that leaves io_q unchanged.
REQ-024 A commit with io_pending low and no write SHALL be legal: io_q is reloaded with the unchanged shadow, and io_changed stays low.
REQ-025 io_lock high at an edge SHALL set io_locked; only reset clears it.
REQ-026 While io_locked is high, or when io_lock is asserted in the same cycle, io_wen SHALL be rejected: shadow and pending unchanged, io_werr pulses high the next cycle.
REQ-027 Commits SHALL remain functional while locked, so that a value written before the lock can still be applied.
REQ-028 Without a commit, io_q SHALL hold its value indefinitely; arithmetic is bitwise only, with no carries and no wrap.

Reset
REQ-029 While reset is low at an edge: io_q = io_shadow = RESET_VAL, and io_pending = io_locked = io_changed = io_werr = 0.
REQ-030 Reset SHALL override any write, commit or lock in the same cycle, including reset asserted between a write and its commit.
REQ-031 Reset SHALL have no asynchronous effect; outputs change only at clock edges.

Structure
REQ-032 The op encodings (WRITE/SET/CLEAR/TOGGLE) SHALL live in the shared sirv peripheral package as named constants.
REQ-033 Per-lane next-value logic SHALL be a sub-module sirv_shadow_reg_lane (8 bits: op, strobe, data, shadow in -> shadow out), instantiated WIDTH/8 times.
REQ-034 The top level SHALL hold all flops: active, shadow, pending, locked, changed, werr.

Verification (WIDTH=32, RESET_VAL=0)
REQ-035 Reset release, then WRITE d=0x12345678 strb=0xF -> shadow=0x12345678, pending=1, q=0; next cycle commit -> q=0x12345678, changed pulses 1 cycle, pending=0.
REQ-036 From shadow 0x000000FF: SET d=0xFF00 strb=0x2 -> 0x0000FFFF; then CLEAR d=0x0F strb=0x1 -> 0x0000FFF0; then TOGGLE d=0xFFFFFFFF strb=0x8 -> 0xFF00FFF0.
REQ-037 Same-cycle WRITE d=0xA5A5A5A5 strb=0xF and commit -> next cycle q=0xA5A5A5A5, pending=0, changed=1.
REQ-038 Commit with shadow equal to q=0x5 -> changed stays 0, q=0x5.
REQ-039 WRITE 0x1, then lock, then WRITE 0x2 -> werr pulses, shadow=0x1; commit -> q=0x1; locked stays 1 until reset.
REQ-040 WRITE 0xDEAD with reset low in the same cycle -> shadow=0, q=0, pending=0; a later commit leaves q=0.
